epcq_op_sequencer: RTL

- Autonomous command sequencer for the ASMII/EPCQ flash controller IP.
- Converts one host command (read, page write, sector erase, enable-4-byte-address, verify) into the correct sequence of strobes, byte shifts and busy handshakes toward the IP.
- Sits between the local-bus control registers / page DPRAMs and the EPCQ instance, so software no longer hand-times pulses or polls busy edges.
- Generates an internal clock-enable so flash-side strobes are exactly one flash tick wide.

---
 rtl/epcq_op_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/epcq_op_sequencer.sv
// Command sequencer for the ASMII/EPCQ flash IP: turns one host command into
// tick-aligned strobes, byte shifts and busy handshakes toward the IP.
module epcq_op_sequencer #(
    parameter int DIV      = 8,
    parameter int TO_W     = 24,
    parameter int RISE_MAX = 8
) (
    input  logic        lb_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    output logic [7:0]  wbuf_addr,
    input  logic [7:0]  wbuf_data,
    output logic [7:0]  rbuf_addr,
    output logic [7:0]  rbuf_data,
    output logic        rbuf_we,
    output logic [31:0] flash_addr,
    output logic        flash_read,
    output logic        flash_rden,
    output logic        flash_write,
    output logic        flash_shift_bytes,
    output logic        flash_sector_erase,
    output logic        flash_wren,
    output logic        flash_en4b_addr,
    output logic [7:0]  flash_datain,
    input  logic [7:0]  flash_dataout,
    input  logic        flash_busy,
    input  logic        flash_data_valid,
    input  logic        flash_illegal_write,
    input  logic        flash_illegal_erase,
    output logic        seq_busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [8:0]  bytes_done
);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = $clog2(RISE_MAX + 1);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_READ   = 3'd1;
    localparam logic [2:0] OP_PWRITE = 3'd2;
    localparam logic [2:0] OP_ERASE  = 3'd3;
    localparam logic [2:0] OP_EN4B   = 3'd4;
    localparam logic [2:0] OP_VERIFY = 3'd5;

    localparam logic [2:0] E_OP     = 3'd1;
    localparam logic [2:0] E_IWRITE = 3'd2;
    localparam logic [2:0] E_IERASE = 3'd3;
    localparam logic [2:0] E_TMO    = 3'd4;
    localparam logic [2:0] E_VERIFY = 3'd5;
    localparam logic [2:0] E_NORISE = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE, S_STROBE, S_RD_WAIT, S_WR_FETCH, S_WR_SHIFT,
        S_COMMIT, S_WAIT_RISE, S_WAIT_FALL, S_DONE, S_ERROR
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [2:0]     op_q, op_d;
    logic [7:0]     len_q, len_d;
    logic [8:0]     idx_q, idx_d;
    logic [RW-1:0]  rise_q, rise_d;
    logic [TO_W-1:0] to_q, to_d;
    logic           err_q, err_d;
    logic [2:0]     err_code_q, err_code_d;
    logic [8:0]     bytes_done_q, bytes_done_d;
    logic [7:0]     wbuf_addr_q, wbuf_addr_d;
    logic [7:0]     rbuf_addr_q, rbuf_addr_d;
    logic [7:0]     rbuf_data_q, rbuf_data_d;
    logic           rbuf_we_q, rbuf_we_d;
    logic           done_q, done_d;
    logic [31:0]    addr_q, addr_d;
    logic [7:0]     datain_q, datain_d;
    logic           read_q, read_d, rden_q, rden_d, write_q, write_d;
    logic           shift_q, shift_d, erase_q, erase_d, wren_q, wren_d, en4b_q, en4b_d;

    logic       ce;
    logic [7:0] rd_byte, wr_byte;

    assign ce = (tick_q == TW'(DIV - 1));

    // The IP shifts bytes LSB-first relative to the buffers.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rev
            assign rd_byte[gi] = flash_dataout[7-gi];
            assign wr_byte[gi] = wbuf_data[7-gi];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        tick_d       = ce ? '0 : tick_q + TW'(1);
        op_d         = op_q;
        len_d        = len_q;
        idx_d        = idx_q;
        rise_d       = rise_q;
        to_d         = to_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        bytes_done_d = bytes_done_q;
        wbuf_addr_d  = wbuf_addr_q;
        rbuf_addr_d  = rbuf_addr_q;
        rbuf_data_d  = rbuf_data_q;
        rbuf_we_d    = 1'b0;
        done_d       = 1'b0;
        addr_d       = addr_q;
        datain_d     = datain_q;
        read_d       = read_q;
        rden_d       = rden_q;
        write_d      = write_q;
        shift_d      = shift_q;
        erase_d      = erase_q;
        wren_d       = wren_q;
        en4b_d       = en4b_q;

        if (ce) begin
            // Strobes last exactly one tick unless re-asserted below.
            read_d  = 1'b0;
            write_d = 1'b0;
            shift_d = 1'b0;
            erase_d = 1'b0;
            wren_d  = 1'b0;
            en4b_d  = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_d         = cmd_op;
                        len_d        = cmd_len;
                        addr_d       = cmd_addr;
                        err_d        = 1'b0;
                        err_code_d   = 3'd0;
                        bytes_done_d = 9'd0;
                        idx_d        = 9'd0;
                        wbuf_addr_d  = 8'd0;
                        to_d         = '0;
                        case (cmd_op)
                            OP_NOP:    state_d = S_DONE;
                            OP_READ, OP_VERIFY: begin
                                read_d  = 1'b1;
                                rden_d  = 1'b1;
                                state_d = S_STROBE;
                            end
                            OP_PWRITE: state_d = S_WR_FETCH;
                            OP_ERASE: begin
                                erase_d = 1'b1;
                                wren_d  = 1'b1;
                                state_d = S_STROBE;
                            end
                            OP_EN4B: begin
                                en4b_d  = 1'b1;
                                wren_d  = 1'b1;
                                state_d = S_STROBE;
                            end
                            default: begin
                                err_d      = 1'b1;
                                err_code_d = E_OP;
                                state_d    = S_ERROR;
                            end
                        endcase
                    end
                end
                S_STROBE: begin
                    rise_d = '0;
                    to_d   = '0;
                    if (op_q == OP_READ || op_q == OP_VERIFY) begin
                        state_d = S_RD_WAIT;
                    end else if (op_q == OP_ERASE) begin
                        state_d = S_WAIT_RISE;
                    end else begin
                        state_d = S_WAIT_FALL;
                    end
                end
                S_RD_WAIT: begin
                    if (flash_data_valid) begin
                        if (op_q == OP_VERIFY && rd_byte != wbuf_data) begin
                            err_d        = 1'b1;
                            err_code_d   = E_VERIFY;
                            bytes_done_d = idx_q;
                            rden_d       = 1'b0;
                            to_d         = '0;
                            state_d      = S_ERROR;
                        end else begin
                            if (op_q == OP_READ) begin
                                rbuf_we_d   = 1'b1;
                                rbuf_addr_d = idx_q[7:0];
                                rbuf_data_d = rd_byte;
                            end
                            idx_d        = idx_q + 9'd1;
                            bytes_done_d = bytes_done_q + 9'd1;
                            // Prefetch the next compare byte a tick ahead.
                            wbuf_addr_d  = idx_q[7:0] + 8'd1;
                            if (idx_q == {1'b0, len_q}) begin
                                rden_d  = 1'b0;
                                to_d    = '0;
                                state_d = S_WAIT_FALL;
                            end
                        end
                    end
                end
                S_WR_FETCH: begin
                    datain_d     = wr_byte;
                    shift_d      = 1'b1;
                    wren_d       = 1'b1;
                    idx_d        = idx_q + 9'd1;
                    bytes_done_d = bytes_done_q + 9'd1;
                    state_d      = S_WR_SHIFT;
                end
                S_WR_SHIFT: begin
                    if (idx_q == {1'b0, len_q} + 9'd1) begin
                        write_d = 1'b1;
                        wren_d  = 1'b1;
                        state_d = S_COMMIT;
                    end else begin
                        wbuf_addr_d = idx_q[7:0];
                        state_d     = S_WR_FETCH;
                    end
                end
                S_COMMIT: begin
                    rise_d  = '0;
                    state_d = S_WAIT_RISE;
                end
                S_WAIT_RISE: begin
                    if (flash_busy) begin
                        to_d    = '0;
                        state_d = S_WAIT_FALL;
                    end else if (rise_q == RW'(RISE_MAX - 1)) begin
                        if (!err_q) err_code_d = E_NORISE;
                        err_d   = 1'b1;
                        to_d    = '0;
                        state_d = S_WAIT_FALL;
                    end else begin
                        rise_d = rise_q + RW'(1);
                    end
                end
                S_WAIT_FALL: begin
                    if (!flash_busy) begin
                        state_d = S_DONE;
                    end else if (&to_q) begin
                        // Counter stays saturated so ERROR exits at once.
                        if (!err_q) err_code_d = E_TMO;
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
                S_ERROR: begin
                    rden_d = 1'b0;
                    if (!flash_busy || (&to_q)) begin
                        state_d = S_DONE;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            if (state_q != S_IDLE && state_q != S_ERROR &&
                (flash_illegal_write || flash_illegal_erase)) begin
                read_d    = 1'b0;
                rden_d    = 1'b0;
                write_d   = 1'b0;
                shift_d   = 1'b0;
                erase_d   = 1'b0;
                wren_d    = 1'b0;
                en4b_d    = 1'b0;
                rbuf_we_d = 1'b0;
                done_d    = 1'b0;
                to_d      = '0;
                if (!err_q) err_code_d = flash_illegal_write ? E_IWRITE : E_IERASE;
                err_d     = 1'b1;
                state_d   = S_ERROR;
            end
        end
    end

    always_ff @(posedge lb_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            op_q         <= 3'd0;
            len_q        <= 8'd0;
            idx_q        <= 9'd0;
            rise_q       <= '0;
            to_q         <= '0;
            err_q        <= 1'b0;
            err_code_q   <= 3'd0;
            bytes_done_q <= 9'd0;
            wbuf_addr_q  <= 8'd0;
            rbuf_addr_q  <= 8'd0;
            rbuf_data_q  <= 8'd0;
            rbuf_we_q    <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= 32'd0;
            datain_q     <= 8'd0;
            read_q       <= 1'b0;
            rden_q       <= 1'b0;
            write_q      <= 1'b0;
            shift_q      <= 1'b0;
            erase_q      <= 1'b0;
            wren_q       <= 1'b0;
            en4b_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            op_q         <= op_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            rise_q       <= rise_d;
            to_q         <= to_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            bytes_done_q <= bytes_done_d;
            wbuf_addr_q  <= wbuf_addr_d;
            rbuf_addr_q  <= rbuf_addr_d;
            rbuf_data_q  <= rbuf_data_d;
            rbuf_we_q    <= rbuf_we_d;
            done_q       <= done_d;
            addr_q       <= addr_d;
            datain_q     <= datain_d;
            read_q       <= read_d;
            rden_q       <= rden_d;
            write_q      <= write_d;
            shift_q      <= shift_d;
            erase_q      <= erase_d;
            wren_q       <= wren_d;
            en4b_q       <= en4b_d;
        end
    end

    assign cmd_ready          = (state_q == S_IDLE);
    assign seq_busy           = (state_q != S_IDLE);
    assign wbuf_addr          = wbuf_addr_q;
    assign rbuf_addr          = rbuf_addr_q;
    assign rbuf_data          = rbuf_data_q;
    assign rbuf_we            = rbuf_we_q;
    assign flash_addr         = addr_q;
    assign flash_read         = read_q;
    assign flash_rden         = rden_q;
    assign flash_write        = write_q;
    assign flash_shift_bytes  = shift_q;
    assign flash_sector_erase = erase_q;
    assign flash_wren         = wren_q;
    assign flash_en4b_addr    = en4b_q;
    assign flash_datain       = datain_q;
    assign done               = done_q;
    assign err                = err_q;
    assign err_code           = err_code_q;
    assign bytes_done         = bytes_done_q;
endmodule
